// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot controller.
// Timer values are HHMM in BCD, one nibble per digit.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_EXIT     = 2'd2,
        ST_WAIT_REL = 2'd3
    } park_state_t;

    localparam int TIME_W_DEF      = 16;
    localparam int BCD_MM_ONES_LSB = 0;
    localparam int BCD_MM_TENS_LSB = 4;
    localparam int BCD_HH_ONES_LSB = 8;
    localparam int BCD_HH_TENS_LSB = 12;

endpackage

// File: rtl/parking_free_slot_finder.sv
// Combinational lowest-index priority encoder over the free-bay mask.
module parking_free_slot_finder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     free_mask,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        found = |free_mask;
        index = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/parking_slot_controller.sv
// Slot table and entry/exit gate arbiter for N parking bays.
// Grants the lowest free bay on entry, captures the bay timer on exit.
module parking_slot_controller
    import parking_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int SLOT_W  = 2,
    parameter int TIME_W  = TIME_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      entry_req,
    input  logic                      exit_req,
    input  logic [SLOT_W-1:0]         exit_slot,
    input  logic [N_SLOTS-1:0]        timer_hold,
    input  logic [N_SLOTS*TIME_W-1:0] timer_value,
    output logic [N_SLOTS-1:0]        parking_state,
    output logic                      entry_ack,
    output logic                      entry_deny,
    output logic [SLOT_W-1:0]         entry_slot,
    output logic                      exit_ack,
    output logic                      exit_err,
    output logic [TIME_W-1:0]         exit_time,
    output logic [SLOT_W:0]           occupied_count,
    output logic                      full
);

    park_state_t          r_fsm, w_fsm_next;
    logic                 r_svc_exit, w_svc_exit_next;
    logic [N_SLOTS-1:0]   r_parking_state, w_parking_state_next;
    logic [SLOT_W-1:0]    r_entry_slot;
    logic [TIME_W-1:0]    r_exit_time;
    logic [SLOT_W:0]      r_count, w_count_next;

    logic [N_SLOTS-1:0]   w_free;
    logic                 w_found;
    logic [SLOT_W-1:0]    w_free_idx;
    logic [N_SLOTS-1:0]   w_grant_onehot;
    logic [N_SLOTS-1:0]   w_exit_onehot;
    logic                 w_exit_occ;
    logic [TIME_W-1:0]    w_exit_time_sel;
    logic                 w_entry_ack, w_entry_deny, w_exit_ack, w_exit_err;

    // A bay still in its post-exit hold is not allocatable.
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
        assign w_free[gi]         = ~r_parking_state[gi] & ~timer_hold[gi];
        assign w_grant_onehot[gi] = w_found & (w_free_idx == SLOT_W'(gi));
        assign w_exit_onehot[gi]  = (exit_slot == SLOT_W'(gi));
    end

    parking_free_slot_finder #(
        .N     (N_SLOTS),
        .IDX_W (SLOT_W)
    ) u_finder (
        .free_mask (w_free),
        .found     (w_found),
        .index     (w_free_idx)
    );

    // Out-of-range exit_slot matches no bay, so it reads as unoccupied.
    always_comb begin
        w_exit_time_sel = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_exit_time_sel = w_exit_time_sel
                | (timer_value[i*TIME_W +: TIME_W] & {TIME_W{w_exit_onehot[i]}});
        end
    end
    assign w_exit_occ = |(w_exit_onehot & r_parking_state);

    always_comb begin
        w_fsm_next           = r_fsm;
        w_svc_exit_next      = r_svc_exit;
        w_parking_state_next = r_parking_state;
        w_entry_ack          = 1'b0;
        w_entry_deny         = 1'b0;
        w_exit_ack           = 1'b0;
        w_exit_err           = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (exit_req) begin
                    w_fsm_next      = ST_EXIT;
                    w_svc_exit_next = 1'b1;
                end else if (entry_req) begin
                    w_fsm_next      = ST_ENTRY;
                    w_svc_exit_next = 1'b0;
                end
            end
            ST_ENTRY: begin
                w_fsm_next = ST_WAIT_REL;
                if (!entry_req) begin
                    w_fsm_next = ST_IDLE;
                end else if (w_found) begin
                    w_entry_ack          = 1'b1;
                    w_parking_state_next = r_parking_state | w_grant_onehot;
                end else begin
                    w_entry_deny = 1'b1;
                end
            end
            ST_EXIT: begin
                w_fsm_next = ST_WAIT_REL;
                if (!exit_req) begin
                    w_fsm_next = ST_IDLE;
                end else if (w_exit_occ) begin
                    w_exit_ack           = 1'b1;
                    w_parking_state_next = r_parking_state & ~w_exit_onehot;
                end else begin
                    w_exit_err = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!(r_svc_exit ? exit_req : entry_req)) begin
                    w_fsm_next = ST_IDLE;
                end
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_count_next = w_count_next + (SLOT_W+1)'(w_parking_state_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm           <= ST_IDLE;
            r_svc_exit      <= 1'b0;
            r_parking_state <= '0;
            r_entry_slot    <= '0;
            r_exit_time     <= '0;
            r_count         <= '0;
        end else begin
            r_fsm           <= w_fsm_next;
            r_svc_exit      <= w_svc_exit_next;
            r_parking_state <= w_parking_state_next;
            r_count         <= w_count_next;
            if (w_entry_ack) begin
                r_entry_slot <= w_free_idx;
            end
            if (w_exit_ack) begin
                r_exit_time <= w_exit_time_sel;
            end
        end
    end

    // Bypass the holding registers so slot/time are valid alongside the ack pulse.
    assign entry_slot     = w_entry_ack ? w_free_idx : r_entry_slot;
    assign exit_time      = w_exit_ack ? w_exit_time_sel : r_exit_time;
    assign entry_ack      = w_entry_ack;
    assign entry_deny     = w_entry_deny;
    assign exit_ack       = w_exit_ack;
    assign exit_err       = w_exit_err;
    assign parking_state  = r_parking_state;
    assign occupied_count = r_count;
    assign full           = ~w_found;

endmodule

// File: tb/tb_parking_slot_controller.sv
// Directed bench for parking_slot_controller: allocation, deny, billing capture,
// hold blocking, request priority, error pulses and asynchronous reset.
module tb_parking_slot_controller;

    localparam int N = 4;
    localparam int W = 2;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           entry_req = 1'b0;
    logic           exit_req = 1'b0;
    logic [W-1:0]   exit_slot = '0;
    logic [N-1:0]   timer_hold = '0;
    logic [N*T-1:0] timer_value = {16'h2359, 16'h0142, 16'h1207, 16'h0913};
    logic [N-1:0]   parking_state;
    logic           entry_ack, entry_deny, exit_ack, exit_err, full;
    logic [W-1:0]   entry_slot;
    logic [T-1:0]   exit_time;
    logic [W:0]     occupied_count;

    int checks = 0;
    int failures = 0;
    int n_eack = 0, n_edeny = 0, n_xack = 0, n_xerr = 0;

    parking_slot_controller #(.N_SLOTS(N), .SLOT_W(W), .TIME_W(T)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .entry_req      (entry_req),
        .exit_req       (exit_req),
        .exit_slot      (exit_slot),
        .timer_hold     (timer_hold),
        .timer_value    (timer_value),
        .parking_state  (parking_state),
        .entry_ack      (entry_ack),
        .entry_deny     (entry_deny),
        .entry_slot     (entry_slot),
        .exit_ack       (exit_ack),
        .exit_err       (exit_err),
        .exit_time      (exit_time),
        .occupied_count (occupied_count),
        .full           (full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (entry_ack)  n_eack++;
            if (entry_deny) n_edeny++;
            if (exit_ack)   n_xack++;
            if (exit_err)   n_xerr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic entry_txn(input string tag, input int hold, output logic ack,
                             output logic deny, output logic [W-1:0] slot, output int lat);
        int  p0;
        bit  seen;
        p0 = n_eack + n_edeny;
        seen = 1'b0; ack = 1'b0; deny = 1'b0; slot = '0; lat = 0;
        @(posedge clk); #1;
        entry_req = 1'b1;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (entry_ack || entry_deny) begin
                seen = 1'b1; ack = entry_ack; deny = entry_deny; slot = entry_slot; lat = c;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        entry_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pulses"}, 32'(n_eack + n_edeny - p0), 32'd1);
        $display("txn %s entry ack=%0b deny=%0b slot=%0d state=%b count=%0d",
                 tag, ack, deny, slot, parking_state, occupied_count);
    endtask

    task automatic exit_txn(input string tag, input logic [W-1:0] s, input int hold,
                            output logic ack, output logic err, output logic [T-1:0] tm);
        int  p0;
        bit  seen;
        p0 = n_xack + n_xerr;
        seen = 1'b0; ack = 1'b0; err = 1'b0; tm = '0;
        @(posedge clk); #1;
        exit_slot = s;
        exit_req  = 1'b1;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (exit_ack || exit_err) begin
                seen = 1'b1; ack = exit_ack; err = exit_err; tm = exit_time;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        exit_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pulses"}, 32'(n_xack + n_xerr - p0), 32'd1);
        $display("txn %s exit slot=%0d ack=%0b err=%0b time=%h state=%b count=%0d",
                 tag, s, ack, err, tm, parking_state, occupied_count);
    endtask

    initial begin
        logic         ack, deny, err;
        logic [W-1:0] slot;
        logic [T-1:0] tm;
        int           lat;
        int           xc, ec;
        logic [T-1:0] xt;
        logic [W-1:0] es;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(parking_state), 32'h0);
        check("rst_count", 32'(occupied_count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_pulses", 32'({entry_ack, entry_deny, exit_ack, exit_err}), 32'h0);
        check("rst_exit_time", 32'(exit_time), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: four entries fill bays 0..3 in order
        for (int i = 0; i < N; i++) begin
            entry_txn($sformatf("fill%0d", i), 0, ack, deny, slot, lat);
            check($sformatf("fill%0d_ack", i), 32'(ack), 32'd1);
            check($sformatf("fill%0d_slot", i), 32'(slot), 32'(i));
            if (i == 0) check("entry_latency", 32'(lat), 32'd2);
        end
        check("fill_count", 32'(occupied_count), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_state", 32'(parking_state), 32'hF);

        // 2: entry when full is denied
        entry_txn("deny_full", 0, ack, deny, slot, lat);
        check("deny_full_deny", 32'(deny), 32'd1);
        check("deny_full_ack", 32'(ack), 32'd0);
        check("deny_full_state", 32'(parking_state), 32'hF);
        check("deny_full_count", 32'(occupied_count), 32'd4);

        // 3: release bay 2 and capture its timer
        exit_txn("exit2", 2'd2, 0, ack, err, tm);
        check("exit2_ack", 32'(ack), 32'd1);
        check("exit2_time", 32'(tm), 32'h0142);
        check("exit2_state", 32'(parking_state), 32'hB);
        check("exit2_count", 32'(occupied_count), 32'd3);
        check("exit2_time_held", 32'(exit_time), 32'h0142);
        check("exit2_full", 32'(full), 32'd0);

        // 4: a bay in post-exit hold is not allocatable
        timer_hold = 4'b0100;
        #1;
        check("hold_full", 32'(full), 32'd1);
        entry_txn("hold_deny", 0, ack, deny, slot, lat);
        check("hold_deny_deny", 32'(deny), 32'd1);
        check("hold_deny_state", 32'(parking_state), 32'hB);
        timer_hold = 4'b0000;
        entry_txn("hold_clear", 0, ack, deny, slot, lat);
        check("hold_clear_ack", 32'(ack), 32'd1);
        check("hold_clear_slot", 32'(slot), 32'd2);
        check("hold_clear_state", 32'(parking_state), 32'hF);

        // 5: simultaneous requests, exit wins, entry reuses the freed bay
        xc = 0; ec = 0; xt = '0; es = '0;
        @(posedge clk); #1;
        exit_slot = 2'd0;
        exit_req  = 1'b1;
        entry_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (exit_ack && xc == 0) begin xc = c; xt = exit_time; end
            if (entry_ack && ec == 0) begin ec = c; es = entry_slot; end
            @(posedge clk); #1;
            if (xc != 0) exit_req = 1'b0;
            if (ec != 0) entry_req = 1'b0;
            if (xc != 0 && ec != 0) break;
        end
        exit_req = 1'b0;
        entry_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("both_exit_seen", 32'(xc != 0), 32'd1);
        check("both_entry_seen", 32'(ec != 0), 32'd1);
        check("both_exit_first", 32'(xc != 0 && ec > xc), 32'd1);
        check("both_min_gap", 32'((ec - xc) >= 3), 32'd1);
        check("both_exit_time", 32'(xt), 32'h0913);
        check("both_entry_slot", 32'(es), 32'd0);
        check("both_state", 32'(parking_state), 32'hF);
        $display("txn both exit_cyc=%0d entry_cyc=%0d time=%h slot=%0d", xc, ec, xt, es);

        // 6: release bay 1, then a held exit on the empty bay gives one error pulse
        exit_txn("exit1", 2'd1, 0, ack, err, tm);
        check("exit1_time", 32'(tm), 32'h1207);
        check("exit1_state", 32'(parking_state), 32'hD);
        exit_txn("exit1_empty", 2'd1, 4, ack, err, tm);
        check("exit1_empty_err", 32'(err), 32'd1);
        check("exit1_empty_ack", 32'(ack), 32'd0);
        check("exit1_empty_state", 32'(parking_state), 32'hD);
        check("exit1_empty_count", 32'(occupied_count), 32'd3);

        // Reset asserted while the FSM is in EXIT
        @(posedge clk); #1;
        exit_slot = 2'd0;
        exit_req  = 1'b1;
        @(posedge clk); #1;
        check("midrst_pre_ack", 32'(exit_ack), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_ack", 32'(exit_ack), 32'd0);
        check("midrst_state", 32'(parking_state), 32'h0);
        check("midrst_count", 32'(occupied_count), 32'd0);
        check("midrst_exit_time", 32'(exit_time), 32'h0);
        check("midrst_full", 32'(full), 32'd0);
        exit_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("postrst_state", 32'(parking_state), 32'h0);
        check("postrst_exit_time", 32'(exit_time), 32'h0);
        $display("txn midreset state=%b count=%0d time=%h", parking_state, occupied_count, exit_time);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
